// File: rtl/decimal_digit_accumulator.sv
// Accumulates a most-significant-first stream of BCD digits into a W-bit unsigned integer.
// Overflow saturates the value, non-BCD digits are skipped and flagged, and the count saturates.
module decimal_digit_accumulator #(
    parameter int unsigned W     = 32,
    parameter int unsigned CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             digit_valid,
    output logic             digit_ready,
    input  logic [3:0]       digit,
    input  logic             digit_last,
    input  logic             abort,
    output logic             result_valid,
    input  logic             result_ready,
    output logic [W-1:0]     result,
    output logic             overflow,
    output logic             bad_digit,
    output logic [CNT_W-1:0] digit_count
);

    typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

    state_e           state_q, state_d;
    logic [W-1:0]     acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic             bad_q, bad_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;
    logic [W+3:0]     prod;

    assign digit_ready = (state_q != StDone);
    assign accept      = digit_valid & digit_ready;

    // acc*10 = acc*8 + acc*2, widened so the top nibble exposes overflow
    assign prod = {1'b0, acc_q, 3'b000} + {3'b000, acc_q, 1'b0} + {{W{1'b0}}, digit};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        bad_d   = bad_q;
        cnt_d   = cnt_q;
        if (abort) begin
            state_d = StIdle;
            acc_d   = '0;
            ovf_d   = 1'b0;
            bad_d   = 1'b0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle, StAccum: begin
                    if (accept) begin
                        if (digit > 4'd9) begin
                            bad_d = 1'b1;
                        end else if ((prod[W+3:W] != 4'd0) || ovf_q) begin
                            acc_d = '1;
                            ovf_d = 1'b1;
                        end else begin
                            acc_d = prod[W-1:0];
                        end
                        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
                        state_d = digit_last ? StDone : StAccum;
                    end
                end
                StDone: begin
                    if (result_ready) begin
                        state_d = StIdle;
                        acc_d   = '0;
                        ovf_d   = 1'b0;
                        bad_d   = 1'b0;
                        cnt_d   = '0;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            bad_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            bad_q   <= bad_d;
            cnt_q   <= cnt_d;
        end
    end

    assign result_valid = (state_q == StDone);
    assign result       = acc_q;
    assign overflow     = ovf_q;
    assign bad_digit    = bad_q;
    assign digit_count  = cnt_q;

endmodule

// File: tb/tb_decimal_digit_accumulator.sv
// Scoreboard bench: the driver pushes the arithmetic expectation of each number,
// and a monitor compares it against the DUT whenever a result is presented.
module tb_decimal_digit_accumulator;

    typedef struct {
        logic [31:0] r;
        logic        o;
        logic        b;
        logic [4:0]  c;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        digit_valid = 1'b0;
    logic        digit_ready;
    logic [3:0]  digit = 4'd0;
    logic        digit_last = 1'b0;
    logic        abort = 1'b0;
    logic        result_valid;
    logic        result_ready = 1'b0;
    logic [31:0] result;
    logic        overflow;
    logic        bad_digit;
    logic [4:0]  digit_count;

    int          checks = 0;
    int          errors = 0;
    bit          rr_random = 1'b0;
    exp_t        sb[$];
    logic [3:0]  num[$];

    decimal_digit_accumulator #(.W(32), .CNT_W(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .digit_valid  (digit_valid),
        .digit_ready  (digit_ready),
        .digit        (digit),
        .digit_last   (digit_last),
        .abort        (abort),
        .result_valid (result_valid),
        .result_ready (result_ready),
        .result       (result),
        .overflow     (overflow),
        .bad_digit    (bad_digit),
        .digit_count  (digit_count)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endfunction

    // Reference: plain decimal value of the legal digits, saturated at 2^32-1.
    function automatic exp_t model();
        exp_t            e;
        longint unsigned v   = 0;
        bit              ovf = 0;
        bit              bad = 0;
        foreach (num[i]) begin
            if (num[i] > 4'd9) bad = 1;
            else if (!ovf) begin
                v = v * 10 + longint'(num[i]);
                if (v > 64'h0000_0000_FFFF_FFFF) ovf = 1;
            end
        end
        e.r = ovf ? 32'hFFFF_FFFF : v[31:0];
        e.o = ovf;
        e.b = bad;
        e.c = (num.size() > 31) ? 5'd31 : 5'(num.size());
        return e;
    endfunction

    task automatic load_str(input string s);
        num.delete();
        for (int i = 0; i < s.len(); i++) num.push_back(4'(s[i] - 8'd48));
    endtask

    // Called at posedge+1; returns at posedge+1 after the handshake edge.
    task automatic send_digit(input logic [3:0] d, input logic l, input int gap);
        bit taken;
        repeat (gap) begin
            digit = 4'($urandom);
            @(posedge clk);
            #1;
        end
        digit_valid = 1'b1;
        digit       = d;
        digit_last  = l;
        taken       = 1'b0;
        for (int t = 0; t < 100 && !taken; t++) begin
            @(negedge clk);
            taken = digit_ready;
            @(posedge clk);
            #1;
        end
        if (!taken) chk("digit_handshake_timeout", 0, 1);
        digit_valid = 1'b0;
        digit_last  = 1'b0;
    endtask

    task automatic send_digits(input int max_gap);
        foreach (num[i]) send_digit(num[i], i == num.size() - 1, $urandom_range(0, max_gap));
    endtask

    task automatic send_number(input int max_gap);
        sb.push_back(model());
        send_digits(max_gap);
        @(negedge clk);
        chk("valid_latency", result_valid, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int t = 0; t < 200 && sb.size() != 0; t++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    task automatic check_cleared(input string tag);
        @(negedge clk);
        chk({tag, "_valid"}, result_valid, 0);
        chk({tag, "_ready"}, digit_ready, 1);
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        if (rr_random) result_ready = ($urandom_range(0, 3) != 0);
    end

    // Monitor: compare every cycle a result is shown; pop on the handshake.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("ready_vs_valid", digit_ready, !result_valid);
            if (result_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    chk("result", result, sb[0].r);
                    chk("overflow", overflow, sb[0].o);
                    chk("bad_digit", bad_digit, sb[0].b);
                    chk("digit_count", digit_count, sb[0].c);
                    if (result_ready) void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_valid", result_valid, 0);
        chk("rst_result", result, 0);
        chk("rst_ovf", overflow, 0);
        chk("rst_bad", bad_digit, 0);
        chk("rst_count", digit_count, 0);
        chk("rst_ready", digit_ready, 1);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        rr_random = 1'b1;

        load_str("1234");        send_number(0);
        load_str("4294967295");  send_number(0);
        load_str("4294967296");  send_number(1);
        load_str("99999999999"); send_number(2);
        num.delete(); num.push_back(4'd1); num.push_back(4'hA); num.push_back(4'd5);
        send_number(0);
        load_str("0");           send_number(0);
        load_str("000000000000000000000000000000000"); send_number(0);
        drain();

        // Hold the result for 5 cycles while a digit is offered
        rr_random    = 1'b0;
        result_ready = 1'b0;
        load_str("55");
        send_number(0);
        digit_valid = 1'b1;
        digit       = 4'd7;
        digit_last  = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("hold_ready_low", digit_ready, 0);
            @(posedge clk);
            #1;
        end
        load_str("7");
        sb.push_back(model());
        result_ready = 1'b1;
        @(negedge clk);
        chk("done_ready_low", digit_ready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("idle_after_take", digit_ready, 1);
        @(posedge clk);
        #1;
        digit_valid = 1'b0;
        digit_last  = 1'b0;
        @(negedge clk);
        chk("seven_valid", result_valid, 1);
        @(posedge clk);
        #1;
        drain();

        // Abort mid-stream, with a simultaneous digit offer
        rr_random = 1'b1;
        load_str("38");
        foreach (num[i]) send_digit(num[i], 1'b0, 0);
        abort       = 1'b1;
        digit_valid = 1'b1;
        digit       = 4'd9;
        @(posedge clk);
        #1;
        abort       = 1'b0;
        digit_valid = 1'b0;
        check_cleared("abort_mid");
        load_str("6"); send_number(0);
        drain();

        // Abort while a result is held
        rr_random    = 1'b0;
        result_ready = 1'b0;
        load_str("42"); send_number(0);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        void'(sb.pop_back());
        check_cleared("abort_done");
        rr_random = 1'b1;
        load_str("6"); send_number(0);
        drain();

        // Reset pulsed mid-stream
        load_str("38");
        foreach (num[i]) send_digit(num[i], 1'b0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_valid", result_valid, 0);
        chk("midrst_result", result, 0);
        chk("midrst_count", digit_count, 0);
        chk("midrst_ready", digit_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        load_str("6"); send_number(0);
        drain();

        // Random numbers with random gaps and occasional non-BCD digits
        for (int n = 0; n < 40; n++) begin
            int len;
            len = $urandom_range(1, 13);
            num.delete();
            for (int i = 0; i < len; i++) begin
                if ($urandom_range(0, 9) == 0) num.push_back(4'($urandom_range(10, 15)));
                else num.push_back(4'($urandom_range(0, 9)));
            end
            send_number(3);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
